// File: rtl/page_ram_arbiter.sv
// Arbiter for the shared 32 KB page RAM: grants locked bursts to flash-read (R0), flash-write (R1)
// and host (R2), and routes read data back by tag. Optional R0 preemption: PAGE_ARB_PREEMPT_EN.
module page_ram_arbiter #(
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        req2,
  input  logic        en0,
  input  logic        en1,
  input  logic        en2,
  input  logic        we0,
  input  logic        we1,
  input  logic        we2,
  input  logic [14:0] addr0,
  input  logic [14:0] addr1,
  input  logic [14:0] addr2,
  input  logic [7:0]  din0,
  input  logic [7:0]  din1,
  input  logic [7:0]  din2,
  output logic        gnt0,
  output logic        gnt1,
  output logic        gnt2,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        rvalid2,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic [7:0]  rdata2,
  output logic        ram_en,
  output logic        ram_we,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic [1:0]  owner,
  output logic        preempt
);

  // The hold counter is 8 bits wide and saturates, so larger limits could never trigger.
  if (HOLD_MAX > 255) begin : g_hold_max_check
    $error("HOLD_MAX must fit the 8-bit hold counter");
  end

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  rr_last_q, rr_last_d;
  logic        rd_pend_q;
  logic [1:0]  rd_tag_q;
  logic        own_req, own_en, own_we;
  logic [14:0] own_addr;
  logic [7:0]  own_din;
  logic        revoke;

  always_comb begin
    own_req  = 1'b0;
    own_en   = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_din  = '0;
    case (owner_q)
      2'd0: begin own_req = req0; own_en = en0; own_we = we0; own_addr = addr0; own_din = din0; end
      2'd1: begin own_req = req1; own_en = en1; own_we = we1; own_addr = addr1; own_din = din1; end
      2'd2: begin own_req = req2; own_en = en2; own_we = we2; own_addr = addr2; own_din = din2; end
      default: ;
    endcase
  end

  // An access presented in the cycle the owner lets go of req is dropped.
  assign ram_en   = (state_q == StOwn) && own_req && own_en;
  assign ram_we   = ram_en && own_we;
  assign ram_addr = ram_en ? own_addr : '0;
  assign ram_din  = ram_en ? own_din : '0;

  assign gnt0  = (state_q == StOwn) && (owner_q == 2'd0);
  assign gnt1  = (state_q == StOwn) && (owner_q == 2'd1);
  assign gnt2  = (state_q == StOwn) && (owner_q == 2'd2);
  assign owner = owner_q;

`ifdef PAGE_ARB_PREEMPT_EN
  logic [7:0] hold_q, hold_d;
  logic       preempt_q;

  always_comb begin
    hold_d = '0;
    if (state_q == StOwn && owner_q != 2'd0) begin
      hold_d = (hold_q == 8'hff) ? hold_q : hold_q + 8'd1;
    end
  end

  assign revoke  = (state_q == StOwn) && (owner_q != 2'd0) && own_req && req0 &&
                   (32'(hold_q) >= HOLD_MAX);
  assign preempt = preempt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= revoke;
    end
  end
`else
  assign revoke  = 1'b0;
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      StIdle: begin
        if (req0) begin
          state_d = StOwn;
          owner_d = 2'd0;
        end else if (req1 && req2) begin
          state_d   = StOwn;
          owner_d   = (rr_last_q == 2'd2) ? 2'd1 : 2'd2;
          rr_last_d = owner_d;
        end else if (req1 || req2) begin
          state_d   = StOwn;
          owner_d   = req1 ? 2'd1 : 2'd2;
          rr_last_d = owner_d;
        end
      end
      StOwn: begin
        if (!own_req || revoke) begin
          state_d = StIdle;
          owner_d = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 2'd3;
      rr_last_q <= 2'd2;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Read tag is independent of ownership so a burst's final read returns after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 2'd0;
    end else begin
      rd_pend_q <= ram_en && !ram_we;
      if (ram_en && !ram_we) begin
        rd_tag_q <= owner_q;
      end
    end
  end

  assign rvalid0 = rd_pend_q && (rd_tag_q == 2'd0);
  assign rvalid1 = rd_pend_q && (rd_tag_q == 2'd1);
  assign rvalid2 = rd_pend_q && (rd_tag_q == 2'd2);
  assign rdata0  = ram_dout;
  assign rdata1  = ram_dout;
  assign rdata2  = ram_dout;

endmodule

// File: tb/tb_page_ram_arbiter.sv
// Directed bench for page_ram_arbiter with a behavioural 1-cycle-latency page RAM.
module tb_page_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, req2, en0, en1, en2, we0, we1, we2;
  logic [14:0] addr0, addr1, addr2;
  logic [7:0]  din0, din1, din2;
  logic        gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2;
  logic [7:0]  rdata0, rdata1, rdata2;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;
  logic [1:0]  owner;
  logic        preempt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:32767];

  page_ram_arbiter #(.HOLD_MAX(64)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .req2(req2),
    .en0(en0), .en1(en1), .en2(en2),
    .we0(we0), .we1(we1), .we2(we2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .din0(din0), .din1(din1), .din2(din2),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2),
    .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .owner(owner), .preempt(preempt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    {req0, req1, req2, en0, en1, en2, we0, we1, we2} = '0;
    addr0 = '0; addr1 = '0; addr2 = '0;
    din0 = '0; din1 = '0; din2 = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int pre_at;
    int gnt0_at;
    clear_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_owner", 32'(owner), 32'd3);
    check("rst_gnt", 32'({gnt0, gnt1, gnt2}), 32'd0);
    check("rst_rvalid", 32'({rvalid0, rvalid1, rvalid2}), 32'd0);
    check("rst_ram", 32'({ram_en, ram_we, ram_addr, ram_din}), 32'd0);
    check("rst_preempt", 32'(preempt), 32'd0);

    // Single R1 request, write then read back.
    @(negedge clk);
    rst = 1'b0;
    req1 = 1'b1;
    #1 check("gnt1_not_yet", 32'(gnt1), 32'd0);
    @(negedge clk);
    check("gnt1_lat", 32'(gnt1), 32'd1);
    check("owner_r1", 32'(owner), 32'd1);
    en1 = 1'b1; we1 = 1'b1; addr1 = 15'd8192; din1 = 8'h55;
    #1 check("ram_addr_r1", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, 1'b1, 15'd8192}));
    @(negedge clk);
    check("wr_no_rvalid", 32'(rvalid1), 32'd0);
    we1 = 1'b0;
    @(negedge clk);
    check("rvalid1", 32'({rvalid0, rvalid1, rvalid2}), 32'b010);
    check("rdata1", 32'(rdata1), 32'h55);
    en1 = 1'b0;
    @(negedge clk);
    check("rvalid1_pulse", 32'(rvalid1), 32'd0);
    req1 = 1'b0;
    @(negedge clk);
    check("release_r1", 32'({gnt1, owner}), 32'({1'b0, 2'd3}));

    // Round robin between R1 and R2.
    reset_dut();
    req1 = 1'b1; req2 = 1'b1;
    @(negedge clk);
    check("tie1_owner", 32'({gnt1, gnt2, owner}), 32'({1'b1, 1'b0, 2'd1}));
    req1 = 1'b0;
    @(negedge clk);
    check("tie_idle_gap", 32'({gnt1, gnt2, owner}), 32'({1'b0, 1'b0, 2'd3}));
    req1 = 1'b1;
    @(negedge clk);
    check("tie2_owner", 32'({gnt1, gnt2, owner}), 32'({1'b0, 1'b1, 2'd2}));
    req1 = 1'b0; req2 = 1'b0;
    @(negedge clk);
    check("tie_release", 32'(owner), 32'd3);

    // R0 streams 8192 writes while R2 waits with its strobes active.
    req0 = 1'b1; req2 = 1'b1;
    en2 = 1'b1; we2 = 1'b1; addr2 = 15'h7fff; din2 = 8'haa;
    @(negedge clk);
    check("r0_owner", 32'(owner), 32'd0);
    bad = 0;
    for (int i = 0; i < 8192; i++) begin
      en0 = 1'b1; we0 = 1'b1; addr0 = 15'(i); din0 = i[7:0];
      #1;
      if (gnt2 || !ram_en || !ram_we || ram_addr != addr0 || ram_din != din0) bad++;
      @(negedge clk);
    end
    check("r0_burst_clean", 32'(bad), 32'd0);
    req0 = 1'b0; en0 = 1'b0; en2 = 1'b0;
    @(negedge clk);
    check("r2_wait_gap", 32'({gnt2, owner}), 32'({1'b0, 2'd3}));
    @(negedge clk);
    check("r2_after_r0", 32'({gnt2, owner}), 32'({1'b1, 2'd2}));

    // R1 reads on its last cycle while R2 waits; data returns to R1 only.
    req2 = 1'b0;
    @(negedge clk);
    req1 = 1'b1;
    @(negedge clk);
    check("r1_owner2", 32'(owner), 32'd1);
    req2 = 1'b1; en1 = 1'b1; we1 = 1'b0; addr1 = 15'd5;
    @(negedge clk);
    check("last_rd_tag", 32'({rvalid0, rvalid1, rvalid2}), 32'b010);
    check("last_rd_data", 32'(rdata1), 32'h05);
    req1 = 1'b0; we1 = 1'b1; addr1 = 15'd6; din1 = 8'hee;
    #1 check("drop_on_release", 32'(ram_en), 32'd0);
    @(negedge clk);
    check("turnaround", 32'({gnt2, rvalid1, rvalid2, owner}), 32'({3'b000, 2'd3}));
    en1 = 1'b0;
    @(negedge clk);
    check("r2_after_r1", 32'({gnt2, owner}), 32'({1'b1, 2'd2}));

    // Asynchronous reset during an R2 read burst.
    en2 = 1'b1; we2 = 1'b0; addr2 = 15'd8192;
    @(posedge clk);
    #1 check("r2_rvalid", 32'({rvalid2, rdata2}), 32'({1'b1, 8'h55}));
    #1 rst = 1'b1;
    #1 check("async_rst", 32'({gnt2, rvalid2, ram_en, owner}), 32'({3'b000, 2'd3}));
    @(negedge clk);
    rst = 1'b0; req2 = 1'b0; en2 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    check("r0_after_rst", 32'({gnt0, owner}), 32'({1'b1, 2'd0}));
    req0 = 1'b0;
    @(negedge clk);

    // Long R1 hold with R0 waiting from cycle 10.
    req1 = 1'b1;
    @(negedge clk);
    check("hold_owner", 32'(owner), 32'd1);
    pre_at = -1;
    gnt0_at = -1;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (preempt && pre_at < 0) pre_at = j;
      if (gnt0 && gnt0_at < 0) gnt0_at = j;
      if (j == 9) req0 = 1'b1;
    end
`ifdef PAGE_ARB_PREEMPT_EN
    check("preempt_at", 32'(pre_at), 32'd65);
    check("gnt0_after_preempt", 32'(gnt0_at), 32'd66);
`else
    check("no_preempt", 32'(pre_at), 32'hffffffff);
    check("no_gnt0_in_hold", 32'(gnt0_at), 32'hffffffff);
    req1 = 1'b0;
    @(negedge clk);
    check("hold_release", 32'({gnt0, owner}), 32'({1'b0, 2'd3}));
    @(negedge clk);
    check("gnt0_after_hold", 32'({gnt0, owner}), 32'({1'b1, 2'd0}));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
